// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI byte-stream command decoder over a bank of control words and read-only status words.
// Latency: a SET/RESET/WRITE result or READ byte appears one cycle after the i_rx_dv that completes or requests it.
// Backpressure: none; the SPI slave paces every byte, and optional timeout SPI_REG_BANK_TIMEOUT_EN aborts stalled transfers.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_rx_dv, i_rx_byte     byte received from the SPI slave (one-cycle pulse)
//   o_tx_dv, o_tx_byte     byte to load into the SPI slave (one-cycle pulse, byte held)
//   o_regs, o_reg_wr_stb   packed control words and their per-word update strobes
//   i_status               packed read-only status words
//   o_err, i_err_clr       sticky protocol error and its clear
//   o_busy                 high while a multi-byte transfer is in progress
//
// Command byte: [7:6] = SET(0) / RESET(1) / WRITE(2) / READ(3), [5:0] = word address.
// Control words occupy 0..NUM_REGS-1, status words NUM_REGS..NUM_REGS+NUM_STATUS-1.
// Define SPI_REG_BANK_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES idle cycles.

module spi_reg_bank #(
   parameter int NUM_REGS       = 16,
   parameter int NUM_STATUS     = 8,
   parameter int DATA_BYTES     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   input  logic                             i_rx_dv,
   input  logic [7:0]                       i_rx_byte,
   output logic                             o_tx_dv,
   output logic [7:0]                       o_tx_byte,
   output logic [NUM_REGS*DATA_BYTES*8-1:0] o_regs,
   output logic [NUM_REGS-1:0]              o_reg_wr_stb,
   input  logic [NUM_STATUS*DATA_BYTES*8-1:0] i_status,
   output logic                             o_err,
   input  logic                             i_err_clr,
   output logic                             o_busy
);

   localparam int W     = DATA_BYTES * 8;
   localparam int CNT_W = $clog2(DATA_BYTES + 1);

   localparam logic [1:0] OP_SET   = 2'd0;
   localparam logic [1:0] OP_RESET = 2'd1;
   localparam logic [1:0] OP_WRITE = 2'd2;
   localparam logic [1:0] OP_READ  = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      RD_DATA = 2'd2
   } state_t;

   state_t                    state_q;
   logic [5:0]                addr_q;
   logic                      bad_q;      // current WRITE targets a non-writable address
   logic [W-1:0]              shadow_q;
   logic [W-1:0]              snap_q;     // remaining read bytes, next one in the top byte
   logic [CNT_W-1:0]          cnt_q;
   logic [NUM_REGS*W-1:0]     regs_q;
   logic [NUM_REGS-1:0]       wr_stb_q;
   logic                      tx_dv_q;
   logic [7:0]                tx_byte_q;
   logic                      err_q;

   logic [1:0]                cmd_op;
   int                        cmd_addr_int;
   int                        addr_int_q;
   logic                      valid_wr_d;
   logic                      valid_rd_d;
   logic [W-1:0]              rd_word_d;
   logic [W-1:0]              shadow_d;
   logic                      err_set_d;
   logic                      timeout_d;
   logic                      last_byte_d;

   // ---------------------------------------------------------------
   // Command decode and read-word selection
   // ---------------------------------------------------------------
   always_comb begin
      cmd_op       = i_rx_byte[7:6];
      cmd_addr_int = int'(i_rx_byte[5:0]);
      addr_int_q   = int'(addr_q);
      valid_wr_d   = cmd_addr_int < NUM_REGS;
      valid_rd_d   = cmd_addr_int < (NUM_REGS + NUM_STATUS);

      // Unmapped addresses read as all zeros.
      rd_word_d = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (cmd_addr_int == k) rd_word_d = regs_q[k*W +: W];
      end
      for (int k = 0; k < NUM_STATUS; k++) begin
         if (cmd_addr_int == NUM_REGS + k) rd_word_d = i_status[k*W +: W];
      end

      // Bytes arrive MSB first, so each new byte enters at the bottom.
      shadow_d    = (shadow_q << 8) | W'(i_rx_byte);
      last_byte_d = (cnt_q == CNT_W'(DATA_BYTES - 1));
   end

`ifdef SPI_REG_BANK_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt_q;

   // Fires on the cycle the idle count would reach TIMEOUT_CYCLES.
   assign timeout_d = (state_q != IDLE) && !i_rx_dv &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tmo_cnt_q <= '0;
      end else if (state_q == IDLE || i_rx_dv || timeout_d) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   logic unused_tmo;
   assign unused_tmo = |TIMEOUT_CYCLES;
   assign timeout_d  = 1'b0;
`endif

   // Error events: bad address on any command, or an aborted transfer.
   always_comb begin
      err_set_d = timeout_d;
      if (i_rx_dv && state_q == IDLE) begin
         if (cmd_op == OP_READ) begin
            if (!valid_rd_d) err_set_d = 1'b1;
         end else begin
            if (!valid_wr_d) err_set_d = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Main FSM with registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         bad_q     <= 1'b0;
         shadow_q  <= '0;
         snap_q    <= '0;
         cnt_q     <= '0;
         regs_q    <= '0;
         wr_stb_q  <= '0;
         tx_dv_q   <= 1'b0;
         tx_byte_q <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         wr_stb_q <= '0;
         tx_dv_q  <= 1'b0;

         // A new error wins over a simultaneous clear.
         if (err_set_d) begin
            err_q <= 1'b1;
         end else if (i_err_clr) begin
            err_q <= 1'b0;
         end

         if (timeout_d) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            cnt_q    <= '0;
         end else if (i_rx_dv) begin
            case (state_q)
               IDLE: begin
                  addr_q   <= i_rx_byte[5:0];
                  shadow_q <= '0;
                  cnt_q    <= '0;
                  case (cmd_op)
                     OP_SET, OP_RESET: begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                           if (cmd_addr_int == k) begin
                              regs_q[k*W]  <= (cmd_op == OP_SET);
                              wr_stb_q[k]  <= 1'b1;
                           end
                        end
                     end
                     OP_WRITE: begin
                        state_q <= WR_DATA;
                        bad_q   <= !valid_wr_d;
                     end
                     default: begin
                        // READ: snapshot now so later word updates cannot tear the reply.
                        tx_byte_q <= rd_word_d[W-1 -: 8];
                        tx_dv_q   <= 1'b1;
                        snap_q    <= rd_word_d << 8;
                        cnt_q     <= CNT_W'(1);
                        if (DATA_BYTES > 1) state_q <= RD_DATA;
                     end
                  endcase
               end

               WR_DATA: begin
                  shadow_q <= shadow_d;
                  if (last_byte_d) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                     if (!bad_q) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                           if (addr_int_q == k) begin
                              regs_q[k*W +: W] <= shadow_d;
                              wr_stb_q[k]      <= 1'b1;
                           end
                        end
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               RD_DATA: begin
                  // Received byte is a dummy; it only clocks out the next byte.
                  tx_byte_q <= snap_q[W-1 -: 8];
                  tx_dv_q   <= 1'b1;
                  snap_q    <= snap_q << 8;
                  if (last_byte_d) begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end

               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_tx_dv      = tx_dv_q;
   assign o_tx_byte    = tx_byte_q;
   assign o_regs       = regs_q;
   assign o_reg_wr_stb = wr_stb_q;
   assign o_err        = err_q;
   assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed checks of spi_reg_bank with default parameters.
// Latency: results sampled 1 ns after the edge that follows each driven byte.
// Backpressure: none; bytes are driven one per two cycles.

module tb_spi_reg_bank;

   localparam int NR = 16;
   localparam int NS = 8;
   localparam int DB = 2;
   localparam int W  = DB * 8;

   logic               i_clk;
   logic               i_rst;
   logic               i_rx_dv;
   logic [7:0]         i_rx_byte;
   logic               o_tx_dv;
   logic [7:0]         o_tx_byte;
   logic [NR*W-1:0]    o_regs;
   logic [NR-1:0]      o_reg_wr_stb;
   logic [NS*W-1:0]    i_status;
   logic               o_err;
   logic               i_err_clr;
   logic               o_busy;

   int checks = 0;
   int errors = 0;
   logic [NR*W-1:0] exp_regs;

   spi_reg_bank #(
      .NUM_REGS(NR), .NUM_STATUS(NS), .DATA_BYTES(DB), .TIMEOUT_CYCLES(1024)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_rx_dv(i_rx_dv), .i_rx_byte(i_rx_byte),
      .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .o_regs(o_regs),
      .o_reg_wr_stb(o_reg_wr_stb), .i_status(i_status), .o_err(o_err),
      .i_err_clr(i_err_clr), .o_busy(o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drives one byte for one cycle; returns 1 ns after the edge that sampled it.
   task automatic send_byte(input logic [7:0] b);
      @(posedge i_clk); #1;
      i_rx_dv   = 1'b1;
      i_rx_byte = b;
      @(posedge i_clk); #1;
      i_rx_dv   = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_rst     = 1'b1;
      i_rx_dv   = 1'b0;
      i_rx_byte = 8'h00;
      i_err_clr = 1'b0;
      i_status  = '0;
      i_status[2*W +: W] = 16'h5A3C;
      exp_regs  = '0;
      idle_cycles(2);
      i_rst = 1'b0;
      idle_cycles(1);

      // Reset state
      check_val("rst_regs",  o_regs, '0);
      check_val("rst_stb",   o_reg_wr_stb, '0);
      check_val("rst_txdv",  o_tx_dv, 0);
      check_val("rst_txb",   o_tx_byte, 8'h00);
      check_val("rst_err",   o_err, 0);
      check_val("rst_busy",  o_busy, 0);

      // WRITE 0xABCD to word 3; partial write must not show
      send_byte(8'h83);
      check_val("wr_busy", o_busy, 1);
      send_byte(8'hAB);
      check_val("wr_partial", o_regs[3*W +: W], 16'h0000);
      check_val("wr_partial_stb", o_reg_wr_stb, '0);
      send_byte(8'hCD);
      exp_regs[3*W +: W] = 16'hABCD;
      check_val("wr_word3", o_regs[3*W +: W], 16'hABCD);
      check_val("wr_stb", o_reg_wr_stb, 16'h0008);
      check_val("wr_idle", o_busy, 0);
      idle_cycles(1);
      check_val("wr_stb_pulse", o_reg_wr_stb, '0);

      // READ word 3
      send_byte(8'hC3);
      check_val("rd0_dv", o_tx_dv, 1);
      check_val("rd0_byte", o_tx_byte, 8'hAB);
      check_val("rd_busy", o_busy, 1);
      idle_cycles(1);
      check_val("rd_dv_low", o_tx_dv, 0);
      check_val("rd_hold", o_tx_byte, 8'hAB);
      send_byte(8'h00);
      check_val("rd1_dv", o_tx_dv, 1);
      check_val("rd1_byte", o_tx_byte, 8'hCD);
      check_val("rd_done", o_busy, 0);

      // SET / RESET word 5, then RESET / SET on word 3
      send_byte(8'h05);
      check_val("set5", o_regs[5*W +: W], 16'h0001);
      check_val("set5_stb", o_reg_wr_stb, 16'h0020);
      send_byte(8'h45);
      check_val("clr5", o_regs[5*W +: W], 16'h0000);
      check_val("clr5_stb", o_reg_wr_stb, 16'h0020);
      send_byte(8'h43);
      check_val("clr3", o_regs[3*W +: W], 16'hABCC);
      send_byte(8'h03);
      check_val("set3", o_regs[3*W +: W], 16'hABCD);
      check_val("set_busy", o_busy, 0);

      // READ status word 2 (address 18)
      send_byte(8'hD2);
      check_val("st0", o_tx_byte, 8'h5A);
      send_byte(8'hFF);
      check_val("st1", o_tx_byte, 8'h3C);
      check_val("st_err", o_err, 0);

      // WRITE to status address 16 is rejected
      send_byte(8'h90);
      check_val("badwr_err", o_err, 1);
      send_byte(8'h11);
      send_byte(8'h22);
      check_val("badwr_regs", o_regs, exp_regs);
      check_val("badwr_stb", o_reg_wr_stb, '0);
      check_val("badwr_idle", o_busy, 0);

      // Clear, then clear coinciding with a new error
      @(posedge i_clk); #1; i_err_clr = 1'b1;
      @(posedge i_clk); #1; i_err_clr = 1'b0;
      check_val("err_clr", o_err, 0);
      @(posedge i_clk); #1;
      i_rx_dv = 1'b1; i_rx_byte = 8'h10; i_err_clr = 1'b1;
      @(posedge i_clk); #1;
      i_rx_dv = 1'b0; i_err_clr = 1'b0;
      check_val("err_set_wins", o_err, 1);
      check_val("badset_regs", o_regs, exp_regs);

      // READ of unmapped address 24
      send_byte(8'hD8);
      check_val("unm0_dv", o_tx_dv, 1);
      check_val("unm0", o_tx_byte, 8'h00);
      send_byte(8'h55);
      check_val("unm1", o_tx_byte, 8'h00);
      check_val("unm_idle", o_busy, 0);

      @(posedge i_clk); #1; i_err_clr = 1'b1;
      @(posedge i_clk); #1; i_err_clr = 1'b0;

      // Stalled write
      send_byte(8'h83);
      send_byte(8'h12);
      idle_cycles(1100);
`ifdef SPI_REG_BANK_TIMEOUT_EN
      check_val("tmo_idle", o_busy, 0);
      check_val("tmo_err", o_err, 1);
      check_val("tmo_word3", o_regs[3*W +: W], 16'hABCD);
      send_byte(8'hC3);
      check_val("tmo_rd0", o_tx_byte, 8'hAB);
      send_byte(8'h00);
      check_val("tmo_rd1", o_tx_byte, 8'hCD);
      send_byte(8'h83);
      send_byte(8'h12);
`else
      check_val("stall_busy", o_busy, 1);
      check_val("stall_err", o_err, 0);
      check_val("stall_word3", o_regs[3*W +: W], 16'hABCD);
`endif

      // Reset mid-transfer
      @(posedge i_clk); #1; i_rst = 1'b1;
      @(posedge i_clk); #1; i_rst = 1'b0;
      check_val("mrst_regs", o_regs, '0);
      check_val("mrst_stb", o_reg_wr_stb, '0);
      check_val("mrst_txdv", o_tx_dv, 0);
      check_val("mrst_txb", o_tx_byte, 8'h00);
      check_val("mrst_err", o_err, 0);
      check_val("mrst_busy", o_busy, 0);
      send_byte(8'hC3);
      check_val("mrst_rd0_dv", o_tx_dv, 1);
      check_val("mrst_rd0", o_tx_byte, 8'h00);
      check_val("mrst_rd_busy", o_busy, 1);
      send_byte(8'h00);
      check_val("mrst_rd1_dv", o_tx_dv, 1);
      check_val("mrst_rd1", o_tx_byte, 8'h00);
      check_val("mrst_rd_idle", o_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
